// File: rtl/fft_frame_serializer.sv
// Captures a 512-sample frame in one cycle and streams it as 32 beats of 16 lanes under valid/ready.
// Define FFT_SER_DBUF_EN to add a pending frame buffer so a frame can arrive while another streams.
module fft_frame_serializer #(
  parameter int DW = 13,
  parameter int N  = 512,
  parameter int P  = 16,
  localparam int BEATS = N / P,
  localparam int BW    = $clog2(BEATS),
  localparam int AW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic signed [DW-1:0] din [0:N-1],
  input  logic                 din_valid,
  output logic signed [DW-1:0] dout [0:P-1],
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic [BW-1:0]        beat_idx,
  output logic                 busy,
  output logic                 overflow
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state, next_state;
  logic [BW-1:0]        beat, next_beat;
  logic signed [DW-1:0] act_mem [0:N-1];
  logic                 load_din, set_ovf, pend_full;
  logic                 handshake, final_hs;

`ifdef FFT_SER_DBUF_EN
  logic signed [DW-1:0] pend_mem [0:N-1];
  logic                 load_pend, write_pend, next_pend_full;
`else
  assign pend_full = 1'b0;
`endif

  assign handshake = (state == STREAM) && dout_ready;
  assign final_hs  = handshake && (beat == BW'(BEATS - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    next_state = state;
    next_beat  = beat;
    load_din   = 1'b0;
    set_ovf    = 1'b0;
`ifdef FFT_SER_DBUF_EN
    load_pend      = 1'b0;
    write_pend     = 1'b0;
    next_pend_full = pend_full;
`endif
    case (state)
      IDLE: begin
        if (din_valid) begin
          load_din   = 1'b1;
          next_state = STREAM;
          next_beat  = '0;
        end
      end
      STREAM: begin
        if (final_hs) begin
          next_beat = '0;
`ifdef FFT_SER_DBUF_EN
          if (pend_full) begin
            // Pending frame moves to active; a coincident new frame refills pending.
            load_pend      = 1'b1;
            write_pend     = din_valid;
            next_pend_full = din_valid;
          end else if (din_valid) begin
            load_din = 1'b1;
          end else begin
            next_state = IDLE;
          end
`else
          if (din_valid) load_din = 1'b1;
          else           next_state = IDLE;
`endif
        end else begin
          if (handshake) next_beat = beat + BW'(1);
          if (din_valid) begin
`ifdef FFT_SER_DBUF_EN
            if (pend_full) begin
              set_ovf = 1'b1;
            end else begin
              write_pend     = 1'b1;
              next_pend_full = 1'b1;
            end
`else
            set_ovf = 1'b1;
`endif
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      beat     <= '0;
      overflow <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state <= next_state;
      beat  <= next_beat;
      if (set_ovf) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: frame buffers are flop arrays loaded in one cycle, so they are reset like any other state.
      for (int i = 0; i < N; i++) act_mem[i] <= '0;
    end else if (load_din) begin
      for (int i = 0; i < N; i++) act_mem[i] <= din[i];
`ifdef FFT_SER_DBUF_EN
    end else if (load_pend) begin
      for (int i = 0; i < N; i++) act_mem[i] <= pend_mem[i];
`endif
    end
  end

`ifdef FFT_SER_DBUF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) pend_mem[i] <= '0;
      pend_full <= 1'b0;
    end else begin
      if (write_pend) begin
        for (int i = 0; i < N; i++) pend_mem[i] <= din[i];
      end
      pend_full <= next_pend_full;
    end
  end
`endif

  assign dout_valid = (state == STREAM);
  assign dout_last  = dout_valid && (beat == BW'(BEATS - 1));
  assign beat_idx   = beat;
  assign busy       = dout_valid || pend_full;

  // Output lanes come straight from the active buffer; forced to zero outside STREAM.
  always_comb begin
    for (int k = 0; k < P; k++) begin
      dout[k] = dout_valid ? act_mem[AW'(int'(beat) * P + k)] : '0;
    end
  end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Directed scoreboard bench for fft_frame_serializer; expected beats are queued when a frame is driven.
module tb_fft_frame_serializer;

  localparam int DW = 13;
  localparam int N  = 512;
  localparam int P  = 16;
  localparam int BEATS = N / P;

  typedef struct {
    logic [P*DW-1:0] data;
    int              idx;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic signed [DW-1:0] din [0:N-1];
  logic                 din_valid = 1'b0;
  logic signed [DW-1:0] dout [0:P-1];
  logic                 dout_valid;
  logic                 dout_ready = 1'b1;
  logic                 dout_last;
  logic [4:0]           beat_idx;
  logic                 busy;
  logic                 overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cycles, first_valid, last_valid;
  exp_t exp_q[$];
  logic            prev_stall = 1'b0;
  logic [P*DW-1:0] prev_data;
  logic [4:0]      prev_idx;

  fft_frame_serializer #(.DW(DW), .N(N), .P(P)) dut (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .beat_idx(beat_idx), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [P*DW-1:0] pack_dout();
    logic [P*DW-1:0] v;
    for (int k = 0; k < P; k++) v[k*DW +: DW] = dout[k];
    return v;
  endfunction

  function automatic logic [P*DW-1:0] beat_of(input int b);
    logic [P*DW-1:0] v;
    for (int k = 0; k < P; k++) v[k*DW +: DW] = din[b*P + k];
    return v;
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       din[i] = DW'(i - 256);
        1:       din[i] = DW'(100);
        2:       din[i] = DW'(255 - i);
        default: din[i] = (i % 2 == 0) ? DW'(-4096) : DW'(4095);
      endcase
    end
  endtask

  task automatic push_frame();
    for (int b = 0; b < BEATS; b++) exp_q.push_back('{data: beat_of(b), idx: b});
  endtask

  task automatic clr_stats();
    valid_cycles = 0;
    first_valid  = -1;
    last_valid   = -1;
  endtask

  // Samples outputs 1 time unit after the input-drive point, well away from posedge.
  task automatic monitor();
    exp_t e;
    if (dout_valid) begin
      valid_cycles++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
    end else begin
      chk("last_when_idle", dout_last, 1'b0);
    end
    if (prev_stall) begin
      chk("stall_valid", dout_valid, 1'b1);
      chk("stall_data", pack_dout(), prev_data);
      chk("stall_idx", beat_idx, prev_idx);
    end
    if (dout_valid && dout_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_beat observed=beat%0d expected=none", beat_idx);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", pack_dout(), e.data);
        chk("beat_idx", beat_idx, e.idx);
        chk("beat_last", dout_last, e.idx == BEATS - 1);
      end
    end
    prev_stall = dout_valid && !dout_ready;
    prev_data  = pack_dout();
    prev_idx   = beat_idx;
    cyc++;
  endtask

  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic start_frame(input int kind);
    fill(kind);
    din_valid = 1'b1;
    push_frame();
    tick();
    din_valid = 1'b0;
  endtask

  // Runs until the scoreboard drains and valid drops; optionally injects a frame at a given beat.
  task automatic run(input int alt_ready, input int inj_beat, input int inj_kind,
                     input bit inj_push, input int budget);
    bit done = 1'b0;
    bit injected = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0 && !dout_valid) begin
        done = 1'b1;
        break;
      end
      dout_ready = (alt_ready != 0) ? (c % 2 == 0) : 1'b1;
      if (inj_beat >= 0 && !injected && dout_valid && beat_idx == 5'(inj_beat)) begin
        fill(inj_kind);
        din_valid = 1'b1;
        if (inj_push) push_frame();
        injected = 1'b1;
      end
      tick();
      din_valid = 1'b0;
    end
    dout_ready = 1'b1;
    chk("drain_in_budget", done, 1'b1);
    for (int c = 0; c < 4; c++) tick();
  endtask

  initial begin
    int din_cyc;
    bit hit;
    fill(0);
    clr_stats();
    @(negedge clk);
    #1;
    chk("rst_dout", pack_dout(), '0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_last", dout_last, 1'b0);
    chk("rst_idx", beat_idx, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Ramp frame, ready held high.
    clr_stats();
    din_cyc = cyc;
    start_frame(0);
    run(0, -1, 0, 1'b0, 100);
    chk("ramp_latency", first_valid, din_cyc + 1);
    chk("ramp_valid_cycles", valid_cycles, 32);
    chk("ramp_contiguous", last_valid - first_valid, 31);
    chk("ramp_busy_after", busy, 1'b0);

    // Same frame with ready alternating 1,0,...
    clr_stats();
    start_frame(0);
    run(1, -1, 0, 1'b0, 200);
    chk("alt_valid_cycles", valid_cycles, 63);
    chk("alt_contiguous", last_valid - first_valid, 62);

    // New frame coincident with the beat-31 handshake.
    clr_stats();
    start_frame(0);
    run(0, 31, 2, 1'b1, 200);
    chk("coinc_valid_cycles", valid_cycles, 64);
    chk("coinc_contiguous", last_valid - first_valid, 63);
    chk("coinc_ovf", overflow, 1'b0);

    // Extreme values alternating.
    clr_stats();
    start_frame(3);
    run(0, -1, 0, 1'b0, 100);
    chk("ext_valid_cycles", valid_cycles, 32);

    // Second frame arriving at beat 10.
    clr_stats();
    start_frame(0);
`ifdef FFT_SER_DBUF_EN
    run(0, 10, 1, 1'b1, 200);
    chk("ovl_ovf", overflow, 1'b0);
    chk("ovl_valid_cycles", valid_cycles, 64);
    chk("ovl_contiguous", last_valid - first_valid, 63);
`else
    run(0, 10, 1, 1'b0, 200);
    chk("ovl_ovf", overflow, 1'b1);
    chk("ovl_valid_cycles", valid_cycles, 32);
`endif
    chk("ovl_busy_after", busy, 1'b0);

    // Reset asserted at beat 15.
    start_frame(0);
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (dout_valid && beat_idx == 5'd15) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    chk("mid_reached_beat15", hit, 1'b1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_dout", pack_dout(), '0);
    chk("mid_rst_valid", dout_valid, 1'b0);
    chk("mid_rst_last", dout_last, 1'b0);
    chk("mid_rst_idx", beat_idx, 5'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    clr_stats();
    for (int c = 0; c < 4; c++) tick();
    chk("post_rst_no_residual", valid_cycles, 0);

    clr_stats();
    start_frame(2);
    run(0, -1, 0, 1'b0, 100);
    chk("post_rst_valid_cycles", valid_cycles, 32);
    chk("post_rst_ovf", overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
